blink_sequencer: RTL

Command-driven controller for the LED blink datapath: a prescaled tick counter plus an on/off toggle. On a start command it drives `led_out1` for a programmed number of blinks at a programmed half-period, then reports completion. Start, busy, done and abort signals give it a handshake, so a higher-level controller or testbench can sequence blink patterns instead of using a free-running toggle.

---
 rtl/blink_pkg.sv | 10 +
 rtl/blink_sequencer_if.sv | 25 ++
 rtl/blink_prescaler.sv | 23 ++
 rtl/blink_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared state encoding and default widths for the blink sequencer
package blink_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] OFF  = 2'd2;

    localparam int DEF_CNT_W = 10;
    localparam int DEF_NUM_W = 4;
    localparam int DEF_PER_W = 8;
endpackage

// File: rtl/blink_sequencer_if.sv
// rtl/blink_sequencer_if.sv - command/status handshake between a controller and the blink sequencer
interface blink_sequencer_if
    import blink_pkg::*;
#(
    parameter int NUM_W = DEF_NUM_W,
    parameter int PER_W = DEF_PER_W
);
    logic             start_in1;
    logic             abort_in1;
    logic [NUM_W-1:0] blinks_in1;
    logic [PER_W-1:0] period_in1;
    logic             led_out1;
    logic             busy_out1;
    logic             done_out1;

    modport master (
        output start_in1, abort_in1, blinks_in1, period_in1,
        input  led_out1, busy_out1, done_out1
    );

    modport slave (
        input  start_in1, abort_in1, blinks_in1, period_in1,
        output led_out1, busy_out1, done_out1
    );
endinterface

// File: rtl/blink_prescaler.sv
// rtl/blink_prescaler.sv - free-running wrap counter producing one tick every 2^CNT_W clocks
module blink_prescaler #(
    parameter int CNT_W = blink_pkg::DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = &cnt;
endmodule

// File: rtl/blink_sequencer.sv
// rtl/blink_sequencer.sv - runs a programmed number of LED blinks at a programmed half-period
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W,
    parameter int PER_W = DEF_PER_W
) (
    input  logic               clk_in1,
    input  logic               rst_n_in1,
    blink_sequencer_if.slave   bus
);
    logic [1:0]       state, state_next;
    logic [PER_W-1:0] phase, phase_next;
    logic [PER_W-1:0] per, per_next;
    logic [NUM_W-1:0] remaining, remaining_next;
    logic             led, led_next;
    logic             busy, busy_next;
    logic             done, done_next;

    logic             tick;
    logic             start_ok;
    logic             zero_start;
    logic             phase_end;

    // Abort always beats start, so a simultaneous start/abort in IDLE is dropped.
    assign start_ok   = (state == IDLE) && bus.start_in1 && !bus.abort_in1 &&
                        (bus.blinks_in1 != '0);
    assign zero_start = (state == IDLE) && bus.start_in1 && !bus.abort_in1 &&
                        (bus.blinks_in1 == '0);
    assign phase_end  = (phase == (per - PER_W'(1)));

    blink_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk   (clk_in1),
        .rst_n (rst_n_in1),
        .clear (start_ok),
        .tick  (tick)
    );

    always_ff @(posedge clk_in1 or negedge rst_n_in1) begin
        if (!rst_n_in1) begin
            state     <= IDLE;
            phase     <= '0;
            per       <= '0;
            remaining <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            per       <= per_next;
            remaining <= remaining_next;
            led       <= led_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = ON;
            ON: begin
                if (bus.abort_in1)           state_next = IDLE;
                else if (tick && phase_end)  state_next = OFF;
            end
            OFF: begin
                if (bus.abort_in1)           state_next = IDLE;
                else if (tick && phase_end)  state_next = (remaining == NUM_W'(1)) ? IDLE : ON;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        phase_next     = phase;
        per_next       = per;
        remaining_next = remaining;
        led_next       = led;
        busy_next      = busy;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    remaining_next = bus.blinks_in1;
                    per_next       = (bus.period_in1 == '0) ? PER_W'(1) : bus.period_in1;
                    phase_next     = '0;
                    led_next       = 1'b1;
                    busy_next      = 1'b1;
                end else if (zero_start) begin
                    done_next = 1'b1;
                end
            end
            ON: begin
                if (bus.abort_in1) begin
                    led_next  = 1'b0;
                    busy_next = 1'b0;
                end else if (tick) begin
                    if (phase_end) begin
                        phase_next = '0;
                        led_next   = 1'b0;
                    end else begin
                        phase_next = phase + PER_W'(1);
                    end
                end
            end
            OFF: begin
                if (bus.abort_in1) begin
                    led_next  = 1'b0;
                    busy_next = 1'b0;
                end else if (tick) begin
                    if (phase_end && remaining == NUM_W'(1)) begin
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else if (phase_end) begin
                        remaining_next = remaining - NUM_W'(1);
                        phase_next     = '0;
                        led_next       = 1'b1;
                    end else begin
                        phase_next = phase + PER_W'(1);
                    end
                end
            end
            default: begin
                led_next  = 1'b0;
                busy_next = 1'b0;
            end
        endcase
    end

    assign bus.led_out1  = led;
    assign bus.busy_out1 = busy;
    assign bus.done_out1 = done;
endmodule
